// File: rtl/mm_add_32_result_checker.sv
// mm_add_32_result_checker
// Receiving end of the 32-bit adder benchmark: delays each accepted operand
// pair by LAT cycles, compares the fabric sum against a locally computed
// modulo-2^WIDTH sum, and counts vectors and mismatches.
// Optional first-failure capture: define MM_ADD_CHECKER_FF_CAPTURE_EN.
module mm_add_32_result_checker #(
  parameter int WIDTH       = 32,
  parameter int LAT         = 1,
  parameter int NUM_VECTORS = 500,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             vld_in,
  input  logic [WIDTH-1:0] num_1,
  input  logic [WIDTH-1:0] num_2,
  input  logic [WIDTH-1:0] o_add,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] vec_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic [WIDTH-1:0] ff_num_1,
  output logic [WIDTH-1:0] ff_num_2,
  output logic [WIDTH-1:0] ff_got,
  output logic [WIDTH-1:0] ff_exp,
  output logic [CNT_W-1:0] ff_idx,
  output logic             ff_vld
);

  // Internal accept/retire counters are sized for NUM_VECTORS so that run
  // completion is independent of the (possibly wrapping) CNT_W counters.
  localparam int AW = $clog2(NUM_VECTORS + 1);
  localparam logic [AW-1:0] NV = AW'(NUM_VECTORS);

`ifdef MM_ADD_CHECKER_FF_CAPTURE_EN
  localparam int PW = 3 * WIDTH;
`else
  localparam int PW = WIDTH;
`endif

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_e;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] x);
    return (&x) ? x : x + 1'b1;
  endfunction

  function automatic logic [WIDTH-1:0] wrap_add(input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b);
    return a + b;
  endfunction

  state_e           state_q, state_d;
  logic [AW-1:0]    acc_cnt_q, acc_cnt_d;
  logic [AW-1:0]    cmp_cnt_q, cmp_cnt_d;
  logic [CNT_W-1:0] vec_cnt_q, vec_cnt_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

  logic             run_clr;
  logic             acc_fire;
  logic             vld_p0;
  logic [WIDTH-1:0] sum_p0;
  logic [PW-1:0]    pay_p0;
  logic             tap_vld;
  logic [PW-1:0]    tap_pay;
  logic [WIDTH-1:0] tap_exp;
  logic             cmp_fire;
  logic             mismatch;

  assign run_clr  = start && ((state_q == S_IDLE) || (state_q == S_DONE));
  assign acc_fire = (state_q == S_RUN) && vld_in;

  // ---- p0: accept stage, expected sum formed from the live operands
  assign vld_p0 = acc_fire;
  assign sum_p0 = wrap_add(num_1, num_2);
`ifdef MM_ADD_CHECKER_FF_CAPTURE_EN
  assign pay_p0 = {num_1, num_2, sum_p0};
`else
  assign pay_p0 = sum_p0;
`endif

  // ---- delay line: LAT stages aligning the expected sum with o_add
  generate
    if (LAT == 0) begin : g_lat0
      assign tap_vld = vld_p0;
      assign tap_pay = pay_p0;
    end else begin : g_dl
      logic [LAT-1:0] vld_q;
      logic [PW-1:0]  pay_q [LAT];

      // Valid bits are control: cleared on reset and on every run start.
      always_ff @(posedge clk) begin
        if (reset || run_clr) begin
          vld_q <= '0;
        end else begin
          vld_q[0] <= vld_p0;
          for (int i = 1; i < LAT; i++) vld_q[i] <= vld_q[i-1];
        end
      end

      // Payload shifts unconditionally; it is only looked at when valid.
      always_ff @(posedge clk) begin
        pay_q[0] <= pay_p0;
        for (int i = 1; i < LAT; i++) pay_q[i] <= pay_q[i-1];
      end

      assign tap_vld = vld_q[LAT-1];
      assign tap_pay = pay_q[LAT-1];
    end
  endgenerate

  // ---- compare stage: retire when valid leaves the delay line
  assign tap_exp  = tap_pay[WIDTH-1:0];
  assign cmp_fire = tap_vld;
  assign mismatch = cmp_fire && (o_add != tap_exp);

  // Next-state logic for the FSM and all counters.
  always_comb begin
    state_d   = state_q;
    acc_cnt_d = acc_cnt_q;
    cmp_cnt_d = cmp_cnt_q;
    vec_cnt_d = vec_cnt_q;
    err_cnt_d = err_cnt_q;

    if (acc_fire) acc_cnt_d = acc_cnt_q + 1'b1;
    if (cmp_fire) begin
      cmp_cnt_d = cmp_cnt_q + 1'b1;
      vec_cnt_d = vec_cnt_q + 1'b1;
      if (mismatch) err_cnt_d = sat_inc(err_cnt_q);
    end

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d   = S_RUN;
          acc_cnt_d = '0;
          cmp_cnt_d = '0;
          vec_cnt_d = '0;
          err_cnt_d = '0;
        end
      end
      S_RUN: begin
        // With LAT=0 the final accept also retires, so skip DRAIN.
        if (acc_fire && (acc_cnt_d == NV)) begin
          state_d = (cmp_cnt_d == NV) ? S_DONE : S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (cmp_cnt_d == NV) state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and counter registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      acc_cnt_q <= '0;
      cmp_cnt_q <= '0;
      vec_cnt_q <= '0;
      err_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      acc_cnt_q <= acc_cnt_d;
      cmp_cnt_q <= cmp_cnt_d;
      vec_cnt_q <= vec_cnt_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign busy    = (state_q == S_RUN) || (state_q == S_DRAIN);
  assign done    = (state_q == S_DONE);
  assign pass    = done && (err_cnt_q == '0);
  assign vec_cnt = vec_cnt_q;
  assign err_cnt = err_cnt_q;

`ifdef MM_ADD_CHECKER_FF_CAPTURE_EN
  logic             ff_vld_q;
  logic [WIDTH-1:0] ff_num_1_q, ff_num_2_q, ff_got_q, ff_exp_q;
  logic [CNT_W-1:0] ff_idx_q;

  // Capture the first mismatching vector of a run; hold until next clear.
  always_ff @(posedge clk) begin
    if (reset || run_clr) begin
      ff_vld_q   <= 1'b0;
      ff_num_1_q <= '0;
      ff_num_2_q <= '0;
      ff_got_q   <= '0;
      ff_exp_q   <= '0;
      ff_idx_q   <= '0;
    end else if (mismatch && !ff_vld_q) begin
      ff_vld_q   <= 1'b1;
      ff_num_1_q <= tap_pay[3*WIDTH-1:2*WIDTH];
      ff_num_2_q <= tap_pay[2*WIDTH-1:WIDTH];
      ff_got_q   <= o_add;
      ff_exp_q   <= tap_exp;
      ff_idx_q   <= vec_cnt_q;
    end
  end

  assign ff_vld   = ff_vld_q;
  assign ff_num_1 = ff_num_1_q;
  assign ff_num_2 = ff_num_2_q;
  assign ff_got   = ff_got_q;
  assign ff_exp   = ff_exp_q;
  assign ff_idx   = ff_idx_q;
`else
  assign ff_vld   = 1'b0;
  assign ff_num_1 = '0;
  assign ff_num_2 = '0;
  assign ff_got   = '0;
  assign ff_exp   = '0;
  assign ff_idx   = '0;
`endif

endmodule

// File: tb/tb_mm_add_32_result_checker.sv
// Bench for mm_add_32_result_checker: four checker instances with different
// LAT / NUM_VECTORS / CNT_W share one operand stream; a behavioural fabric
// produces o_add at each latency, optionally corrupted.
module tb_mm_add_32_result_checker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        vld_in;
  logic        cm;
  logic [3:0]  start_v;
  logic [31:0] num_1, num_2;

  // Behavioural fabric: correct adder, LSB flipped when cm is set.
  logic [31:0] f_in, f1_q;
  logic [31:0] f7_q [7];
  assign f_in = (num_1 + num_2) ^ {31'b0, cm};
  always @(posedge clk) begin
    f1_q    <= f_in;
    f7_q[0] <= f_in;
    for (int i = 1; i < 7; i++) f7_q[i] <= f7_q[i-1];
  end

  logic [3:0]  busy_v, done_v, pass_v, ffvld_v;
  logic [15:0] vec_v [3], err_v [3], ffidx_v [3];
  logic [31:0] ffn1_v [4], ffn2_v [4], ffgot_v [4], ffexp_v [4];
  logic [1:0]  vec_d, err_d, ffidx_d;

  // A: LAT=1 N=8
  mm_add_32_result_checker #(.WIDTH(32), .LAT(1), .NUM_VECTORS(8), .CNT_W(16)) u_a (
    .clk(clk), .reset(rst), .start(start_v[0]), .vld_in(vld_in),
    .num_1(num_1), .num_2(num_2), .o_add(f1_q),
    .busy(busy_v[0]), .done(done_v[0]), .pass(pass_v[0]),
    .vec_cnt(vec_v[0]), .err_cnt(err_v[0]),
    .ff_num_1(ffn1_v[0]), .ff_num_2(ffn2_v[0]), .ff_got(ffgot_v[0]), .ff_exp(ffexp_v[0]),
    .ff_idx(ffidx_v[0]), .ff_vld(ffvld_v[0]));

  // B: LAT=0 N=8
  mm_add_32_result_checker #(.WIDTH(32), .LAT(0), .NUM_VECTORS(8), .CNT_W(16)) u_b (
    .clk(clk), .reset(rst), .start(start_v[1]), .vld_in(vld_in),
    .num_1(num_1), .num_2(num_2), .o_add(f_in),
    .busy(busy_v[1]), .done(done_v[1]), .pass(pass_v[1]),
    .vec_cnt(vec_v[1]), .err_cnt(err_v[1]),
    .ff_num_1(ffn1_v[1]), .ff_num_2(ffn2_v[1]), .ff_got(ffgot_v[1]), .ff_exp(ffexp_v[1]),
    .ff_idx(ffidx_v[1]), .ff_vld(ffvld_v[1]));

  // C: LAT=7 N=8
  mm_add_32_result_checker #(.WIDTH(32), .LAT(7), .NUM_VECTORS(8), .CNT_W(16)) u_c (
    .clk(clk), .reset(rst), .start(start_v[2]), .vld_in(vld_in),
    .num_1(num_1), .num_2(num_2), .o_add(f7_q[6]),
    .busy(busy_v[2]), .done(done_v[2]), .pass(pass_v[2]),
    .vec_cnt(vec_v[2]), .err_cnt(err_v[2]),
    .ff_num_1(ffn1_v[2]), .ff_num_2(ffn2_v[2]), .ff_got(ffgot_v[2]), .ff_exp(ffexp_v[2]),
    .ff_idx(ffidx_v[2]), .ff_vld(ffvld_v[2]));

  // D: LAT=1 N=6 CNT_W=2
  mm_add_32_result_checker #(.WIDTH(32), .LAT(1), .NUM_VECTORS(6), .CNT_W(2)) u_d (
    .clk(clk), .reset(rst), .start(start_v[3]), .vld_in(vld_in),
    .num_1(num_1), .num_2(num_2), .o_add(f1_q),
    .busy(busy_v[3]), .done(done_v[3]), .pass(pass_v[3]),
    .vec_cnt(vec_d), .err_cnt(err_d),
    .ff_num_1(ffn1_v[3]), .ff_num_2(ffn2_v[3]), .ff_got(ffgot_v[3]), .ff_exp(ffexp_v[3]),
    .ff_idx(ffidx_d), .ff_vld(ffvld_v[3]));

  // Observed outputs of the instance under test.
  logic [1:0]  sel;
  logic        m_busy, m_done, m_pass, m_ffvld;
  logic [15:0] m_vec, m_err, m_ffidx;
  logic [31:0] m_ffn1, m_ffn2, m_ffgot, m_ffexp;
  always_comb begin
    m_busy  = busy_v[sel];
    m_done  = done_v[sel];
    m_pass  = pass_v[sel];
    m_ffvld = ffvld_v[sel];
    m_ffn1  = ffn1_v[sel];
    m_ffn2  = ffn2_v[sel];
    m_ffgot = ffgot_v[sel];
    m_ffexp = ffexp_v[sel];
    case (sel)
      2'd0:    begin m_vec = vec_v[0]; m_err = err_v[0]; m_ffidx = ffidx_v[0]; end
      2'd1:    begin m_vec = vec_v[1]; m_err = err_v[1]; m_ffidx = ffidx_v[1]; end
      2'd2:    begin m_vec = vec_v[2]; m_err = err_v[2]; m_ffidx = ffidx_v[2]; end
      default: begin m_vec = {14'b0, vec_d}; m_err = {14'b0, err_d}; m_ffidx = {14'b0, ffidx_d}; end
    endcase
  end

  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  bit          sb_q [$];
  logic [15:0] exp_vec, exp_err, prev_vec, vmask;
  int          s_cyc, l_cyc, d_cyc;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic sb_reset();
    sb_q.delete();
    prev_vec = '0;
    exp_vec  = '0;
    exp_err  = '0;
  endtask

  // One clock; every retire seen on vec_cnt pops one scoreboard entry.
  task automatic tick();
    bit bad;
    @(posedge clk);
    #1;
    cyc++;
    if (m_vec !== prev_vec) begin
      prev_vec = m_vec;
      checks++;
      assert (sb_q.size() > 0) else begin
        failures++;
        $error("FAIL sb_unexpected_compare: observed vec_cnt=%0d expected no compare", m_vec);
      end
      if (sb_q.size() > 0) begin
        bad     = sb_q.pop_front();
        exp_vec = (exp_vec + 16'd1) & vmask;
        if (bad && (exp_err != vmask)) exp_err = exp_err + 16'd1;
        chk("sb_vec_cnt", m_vec, exp_vec);
        chk("sb_err_cnt", m_err, exp_err);
      end
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] b,
                       input logic bad, input bit push);
    vld_in = v;
    num_1  = a;
    num_2  = b;
    cm     = bad;
    if (push) sb_q.push_back(bad);
    tick();
    vld_in = 1'b0;
    cm     = 1'b0;
  endtask

  task automatic pulse_start(input int k, input bit clr);
    if (clr) sb_reset();
    s_cyc      = cyc;
    start_v[k] = 1'b1;
    tick();
    start_v[k] = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    while (!m_done && n < budget) begin
      tick();
      n++;
    end
    chk("done_within_budget", m_done, 1);
    d_cyc = cyc;
  endtask

  task automatic run_toggle(input int k);
    pulse_start(k, 1);
    for (int i = 0; i < 8; i++) begin
      if (i > 0) drive(1'b0, 32'h0, 32'h0, 1'b0, 0);
      drive(1'b1, $urandom, $urandom, 1'b0, 1);
      l_cyc = cyc - 1;
    end
  endtask

  initial begin
    rst = 1'b1; start_v = '0; vld_in = 1'b0; num_1 = '0; num_2 = '0; cm = 1'b0;
    sel = 2'd0; vmask = 16'hFFFF;
    sb_reset();
    tick(); tick();
    rst = 1'b0;

    // Reset values
    chk("rst_busy", m_busy, 0);
    chk("rst_done", m_done, 0);
    chk("rst_pass", m_pass, 0);
    chk("rst_vec", m_vec, 0);
    chk("rst_err", m_err, 0);
    chk("rst_ff_vld", m_ffvld, 0);
    chk("rst_ff_idx", m_ffidx, 0);
    chk("rst_ff_got", m_ffgot, 0);

    // A: clean run, vld held high (including the ignored start cycle)
    vld_in = 1'b1; num_1 = 32'h1234; num_2 = 32'h5678;
    pulse_start(0, 1);
    chk("a1_busy_after_start", m_busy, 1);
    for (int i = 0; i < 8; i++)
      drive(1'b1, (i == 3) ? 32'hFFFF_FFFF : $urandom, (i == 3) ? 32'h1 : $urandom, 1'b0, 1);
    wait_done(40);
    chk("a1_done_latency", d_cyc - s_cyc, 10);
    chk("a1_vec", m_vec, 8);
    chk("a1_err", m_err, 0);
    chk("a1_pass", m_pass, 1);
    chk("a1_ff_vld", m_ffvld, 0);
    chk("a1_sb_empty", sb_q.size(), 0);

    // A: vector 3 corrupted (0xFFFFFFFF + 1 reported as 1)
    pulse_start(0, 1);
    for (int i = 0; i < 8; i++)
      drive(1'b1, (i == 3) ? 32'hFFFF_FFFF : $urandom, (i == 3) ? 32'h1 : $urandom, i == 3, 1);
    wait_done(40);
    chk("a2_vec", m_vec, 8);
    chk("a2_err", m_err, 1);
    chk("a2_pass", m_pass, 0);
`ifdef MM_ADD_CHECKER_FF_CAPTURE_EN
    chk("a2_ff_vld", m_ffvld, 1);
    chk("a2_ff_idx", m_ffidx, 3);
    chk("a2_ff_exp", m_ffexp, 32'h0);
    chk("a2_ff_got", m_ffgot, 32'h1);
    chk("a2_ff_num_1", m_ffn1, 32'hFFFF_FFFF);
    chk("a2_ff_num_2", m_ffn2, 32'h1);
`else
    chk("a2_ff_vld", m_ffvld, 0);
    chk("a2_ff_got", m_ffgot, 0);
    chk("a2_ff_idx", m_ffidx, 0);
`endif

    // B: LAT=0, vld toggling
    sel = 2'd1;
    run_toggle(1);
    wait_done(40);
    chk("b_done_after_last", d_cyc - l_cyc, 1);
    chk("b_vec", m_vec, 8);
    chk("b_pass", m_pass, 1);
    chk("b_sb_empty", sb_q.size(), 0);

    // C: LAT=7, vld toggling, extra vld and start during DRAIN ignored
    sel = 2'd2;
    run_toggle(2);
    drive(1'b1, $urandom, $urandom, 1'b0, 0);
    drive(1'b1, $urandom, $urandom, 1'b0, 0);
    start_v[2] = 1'b1;
    tick();
    start_v[2] = 1'b0;
    chk("c_busy_after_drain_start", m_busy, 1);
    wait_done(40);
    chk("c_done_after_last", d_cyc - l_cyc, 8);
    chk("c_vec", m_vec, 8);
    chk("c_err", m_err, 0);
    chk("c_pass", m_pass, 1);
    chk("c_sb_empty", sb_q.size(), 0);
    pulse_start(2, 1);
    chk("c_restart_busy", m_busy, 1);
    chk("c_restart_done", m_done, 0);
    chk("c_restart_vec", m_vec, 0);

    // A: reset after 4 accepts, then a clean rerun
    sel = 2'd0;
    pulse_start(0, 1);
    for (int i = 0; i < 4; i++) drive(1'b1, $urandom, $urandom, 1'b0, 1);
    rst = 1'b1;
    sb_reset();
    tick();
    rst = 1'b0;
    chk("mr_busy", m_busy, 0);
    chk("mr_done", m_done, 0);
    chk("mr_pass", m_pass, 0);
    chk("mr_vec", m_vec, 0);
    chk("mr_err", m_err, 0);
    chk("mr_ff_vld", m_ffvld, 0);
    chk("mr_c_busy", busy_v[2], 0);
    pulse_start(0, 1);
    for (int i = 0; i < 8; i++) drive(1'b1, $urandom, $urandom, 1'b0, 1);
    wait_done(40);
    chk("mr_rerun_vec", m_vec, 8);
    chk("mr_rerun_pass", m_pass, 1);

    // D: CNT_W=2, every vector corrupted
    sel = 2'd3;
    vmask = 16'h0003;
    pulse_start(3, 1);
    for (int i = 0; i < 6; i++) drive(1'b1, $urandom, $urandom, 1'b1, 1);
    wait_done(40);
    chk("d_err_sat", m_err, 3);
    chk("d_vec_wrap", m_vec, 2);
    chk("d_pass", m_pass, 0);
`ifdef MM_ADD_CHECKER_FF_CAPTURE_EN
    chk("d_ff_vld", m_ffvld, 1);
    chk("d_ff_idx", m_ffidx, 0);
`else
    chk("d_ff_vld", m_ffvld, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
